// File: rtl/seg_scan_ctrl_if.sv
// Bus between a scan-controller client and seg_scan_ctrl: data/strobe inputs plus decoder/digit drive.
interface seg_scan_ctrl_if #(
    parameter int unsigned NDIG = 4
);
    logic                en;
    logic                load;
    logic [4*NDIG-1:0]   data_in;
    logic [NDIG-1:0]     dp_in;
    logic                lz_en;
    logic [3:0]          nibble;
    logic                seg_blank;
    logic [NDIG-1:0]     dig_en;
    logic                dp;
    logic                frame_done;

    modport master (
        output en, load, data_in, dp_in, lz_en,
        input  nibble, seg_blank, dig_en, dp, frame_done
    );

    modport slave (
        input  en, load, data_in, dp_in, lz_en,
        output nibble, seg_blank, dig_en, dp, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: shadow/display double buffer, dead-time between
// digits, optional leading-zero suppression, one shared hex2seg fed through nibble/seg_blank.
module seg_scan_ctrl #(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned BLANK    = 16
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);
    localparam int unsigned DW   = 4 * NDIG;
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CMAX = (SCAN_DIV > BLANK) ? SCAN_DIV : BLANK;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   shadow, shadow_n, disp, disp_n;
    logic [NDIG-1:0] shadow_dp, shadow_dp_n, disp_dp, disp_dp_n;
    logic            pending, pending_n;
    logic            sup;

    logic [3:0]      nibble_q, nibble_n;
    logic            blank_q, blank_n;
    logic [NDIG-1:0] dig_q, dig_n;
    logic            dp_q, dp_n;
    logic            fd_q, fd_n;

    // Next-state, buffer and registered-output computation
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt;
        shadow_n    = shadow;
        shadow_dp_n = shadow_dp;
        pending_n   = pending;
        disp_n      = disp;
        disp_dp_n   = disp_dp;
        fd_n        = 1'b0;
        nibble_n    = 4'h0;
        blank_n     = 1'b1;
        dig_n       = '0;
        dp_n        = 1'b0;
        sup         = 1'b0;

        if (bus.load) begin
            shadow_n    = bus.data_in;
            shadow_dp_n = bus.dp_in;
            pending_n   = 1'b1;
        end

        // Commit only between frames or while dark, so a frame never mixes old and new data
        if (pending_n && ((state == ST_IDLE) || fd_q)) begin
            disp_n    = shadow_n;
            disp_dp_n = shadow_dp_n;
            pending_n = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (bus.en) begin
                    state_n = ST_BLANK;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            end
            ST_BLANK: begin
                if (!bus.en) begin
                    state_n = ST_IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_n = ST_SHOW;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_SHOW: begin
                if (!bus.en) begin
                    state_n = ST_IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == SHOW_LAST) begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    if (idx == IDX_LAST) begin
                        idx_n = '0;
                        fd_n  = 1'b1;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase

        if (state_n != ST_IDLE)
            nibble_n = disp_n[{idx_n, 2'b00} +: 4];

        // Suppression and lz_en are decided once per slot on entry to SHOW, then held
        if (state_n == ST_SHOW) begin
            if (state == ST_SHOW) begin
                blank_n = blank_q;
                dig_n   = dig_q;
                dp_n    = dp_q;
            end else begin
                sup = bus.lz_en && (idx_n != '0);
                for (int i = 0; i < NDIG; i++)
                    if ((IW'(i) >= idx_n) && (disp_n[4*i +: 4] != 4'h0))
                        sup = 1'b0;
                blank_n = sup;
                dig_n   = sup ? '0 : (NDIG'(1) << idx_n);
                dp_n    = !sup && disp_dp_n[idx_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            pending   <= 1'b0;
            disp      <= '0;
            disp_dp   <= '0;
            nibble_q  <= 4'h0;
            blank_q   <= 1'b1;
            dig_q     <= '0;
            dp_q      <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            shadow    <= shadow_n;
            shadow_dp <= shadow_dp_n;
            pending   <= pending_n;
            disp      <= disp_n;
            disp_dp   <= disp_dp_n;
            nibble_q  <= nibble_n;
            blank_q   <= blank_n;
            dig_q     <= dig_n;
            dp_q      <= dp_n;
            fd_q      <= fd_n;
        end
    end

    assign bus.nibble     = nibble_q;
    assign bus.seg_blank  = blank_q;
    assign bus.dig_en     = dig_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a frame-position model predicts every output each cycle.
module tb_seg_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int SD    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = BL + SD;
    localparam int FRAME = NDIG * SLOT;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic [3:0] dig;
        logic       dp;
        logic       fd;
    } obs_t;

    localparam obs_t RST_OBS    = '{nib: 4'h0, blank: 1'b1, dig: 4'h0, dp: 1'b0, fd: 1'b0};
    localparam obs_t BLANK_MASK = '{nib: 4'h0, blank: 1'b1, dig: 4'hF, dp: 1'b1, fd: 1'b1};

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    seg_scan_ctrl_if #(.NDIG(NDIG)) bus();

    seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SD), .BLANK(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        return {bus.nibble, bus.seg_blank, bus.dig_en, bus.dp, bus.frame_done};
    endfunction

    // Expected outputs at cycle p of a scan that started at p=0, given the frame's display contents
    function automatic obs_t model(int p, logic [15:0] d, logic [3:0] dv, bit lz);
        obs_t e;
        int   q, slot;
        bit   sup;
        q    = p % FRAME;
        slot = q / SLOT;
        e    = RST_OBS;
        e.fd = (q == 0) && (p > 0);
        if ((q % SLOT) >= BL) begin
            sup     = lz && (slot > 0) && ((d >> (4 * slot)) == 16'h0);
            e.nib   = 4'((d >> (4 * slot)) & 16'hF);
            e.blank = sup;
            e.dig   = sup ? 4'h0 : 4'(1 << slot);
            e.dp    = dv[slot] && !sup;
        end
        return e;
    endfunction

    // nibble during dead-time is not a visible quantity; ignore it there
    function automatic obs_t mask_for(int p);
        return ((p % SLOT) < BL) ? BLANK_MASK : obs_t'('1);
    endfunction

    function automatic logic [15:0] gen_data();
        logic [15:0] v;
        for (int i = 0; i < NDIG; i++)
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic do_start(input logic [15:0] d, input logic [3:0] dv, input bit lz);
        @(negedge clk);
        rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.lz_en = lz;
        @(negedge clk);
        rst = 1'b0; bus.en = 1'b1; bus.load = 1'b1; bus.data_in = d; bus.dp_in = dv;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.lz_en = 1'b0;
        bus.data_in = 16'h0; bus.dp_in = 4'h0;
        repeat (2) @(negedge clk);
        o = observe(); checks++;
        if (o !== RST_OBS) begin errors++; $display("FAIL reset got=%h exp=%h", o, RST_OBS); end
        bus.en = 1'b1; bus.load = 1'b1; bus.data_in = 16'(($urandom)); bus.dp_in = 4'hF;
        @(negedge clk);
        o = observe(); checks++;
        if (o !== RST_OBS) begin errors++; $display("FAIL reset_wins got=%h exp=%h", o, RST_OBS); end
        rst = 1'b0; bus.en = 1'b0; bus.load = 1'b0;
        repeat (2) @(negedge clk);
        o = observe(); checks++;
        if (o !== RST_OBS) begin errors++; $display("FAIL idle got=%h exp=%h", o, RST_OBS); end
    endtask

    task automatic test_basic();
        obs_t o, e, m;
        do_start(16'h1234, 4'b0101, 1'b0);
        for (int p = 0; p < 3 * FRAME; p++) begin
            o = observe(); e = model(p, 16'h1234, 4'b0101, 1'b0); m = mask_for(p); checks++;
            if ((o & m) !== e) begin errors++; $display("FAIL basic p=%0d got=%h exp=%h", p, o & m, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_midframe();
        obs_t o, e, m;
        logic [15:0] d;
        do_start(16'h1234, 4'b0011, 1'b0);
        for (int p = 0; p < 3 * FRAME; p++) begin
            d = (p < FRAME) ? 16'h1234 : (p < 2 * FRAME) ? 16'hABCD : 16'h5678;
            o = observe(); e = model(p, d, 4'b0011, 1'b0); m = mask_for(p); checks++;
            if ((o & m) !== e) begin errors++; $display("FAIL load_mid p=%0d got=%h exp=%h", p, o & m, e); end
            bus.load = (p == 15) || (p == 30) || (p == 40);
            bus.data_in = (p == 15) ? 16'hABCD : (p == 30) ? 16'(($urandom)) : 16'h5678;
            @(negedge clk);
        end
        bus.load = 1'b0;
    endtask

    task automatic test_lz();
        obs_t o, e, m;
        logic [15:0] d;
        do_start(16'h0050, 4'hF, 1'b1);
        for (int p = 0; p < 2 * FRAME; p++) begin
            d = (p < FRAME) ? 16'h0050 : 16'h0000;
            o = observe(); e = model(p, d, 4'hF, 1'b1); m = mask_for(p); checks++;
            if ((o & m) !== e) begin errors++; $display("FAIL lz p=%0d got=%h exp=%h", p, o & m, e); end
            bus.load = (p == 5); bus.data_in = 16'h0000;
            @(negedge clk);
        end
        bus.load = 1'b0; bus.lz_en = 1'b0;
    endtask

    task automatic test_en_drop();
        obs_t o, e, m;
        logic [15:0] rnd;
        rnd = gen_data();
        do_start(16'h1234, 4'b1000, 1'b0);
        for (int p = 0; p < 15; p++) begin
            o = observe(); e = model(p, 16'h1234, 4'b1000, 1'b0); m = mask_for(p); checks++;
            if ((o & m) !== e) begin errors++; $display("FAIL pre_drop p=%0d got=%h exp=%h", p, o & m, e); end
            if (p == 14) bus.en = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            o = observe(); checks++;
            if (o !== RST_OBS) begin errors++; $display("FAIL en_drop k=%0d got=%h exp=%h", k, o, RST_OBS); end
            bus.load = (k == 1); bus.data_in = rnd; bus.dp_in = 4'b0110;
            bus.en = (k == 3);
            @(negedge clk);
        end
        bus.load = 1'b0;
        for (int p = 0; p < 10; p++) begin
            o = observe(); e = model(p, rnd, 4'b0110, 1'b0); m = mask_for(p); checks++;
            if ((o & m) !== e) begin errors++; $display("FAIL restart p=%0d got=%h exp=%h", p, o & m, e); end
            if (p == 9) rst = 1'b1;
            @(negedge clk);
        end
        o = observe(); checks++;
        if (o !== RST_OBS) begin errors++; $display("FAIL mid_rst got=%h exp=%h", o, RST_OBS); end
        rst = 1'b0;
        @(negedge clk);
        for (int p = 0; p < FRAME; p++) begin
            o = observe(); e = model(p, 16'h0000, 4'h0, 1'b0); m = mask_for(p); checks++;
            if ((o & m) !== e) begin errors++; $display("FAIL post_rst p=%0d got=%h exp=%h", p, o & m, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_on_frame_done();
        obs_t o, e, m;
        logic [15:0] d0, d;
        d0 = gen_data();
        do_start(d0, 4'h0, 1'b0);
        for (int p = 0; p < 3 * FRAME; p++) begin
            d = (p < FRAME) ? d0 : 16'h9999;
            o = observe(); e = model(p, d, 4'h0, 1'b0); m = mask_for(p); checks++;
            if ((o & m) !== e) begin errors++; $display("FAIL fd_load p=%0d got=%h exp=%h", p, o & m, e); end
            bus.load = (p == 10) || (p == FRAME);
            bus.data_in = (p == 10) ? gen_data() : 16'h9999;
            @(negedge clk);
        end
        bus.load = 1'b0;
    endtask

    task automatic test_random_frames();
        obs_t o, e, m;
        logic [15:0] cur, pd;
        logic [3:0]  cdp, pdp;
        bit          lzc, pend;
        int          q;
        cur = gen_data(); cdp = 4'($urandom); lzc = 1'($urandom); pend = 1'b0;
        pd = 16'h0; pdp = 4'h0;
        do_start(cur, cdp, lzc);
        for (int p = 0; p < 10 * FRAME; p++) begin
            q = p % FRAME;
            o = observe(); e = model(p, cur, cdp, lzc); m = mask_for(p); checks++;
            if ((o & m) !== e) begin errors++; $display("FAIL rand p=%0d got=%h exp=%h", p, o & m, e); end
            checks++;
            if ($countones(bus.dig_en) > 1) begin
                errors++; $display("FAIL onehot p=%0d got=%b exp=at most one bit", p, bus.dig_en);
            end
            if (q == 0 && p > 0) begin lzc = 1'($urandom); bus.lz_en = lzc; end
            bus.load = (q == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            if (bus.load) begin
                pd = gen_data(); pdp = 4'($urandom);
                bus.data_in = pd; bus.dp_in = pdp; pend = 1'b1;
            end
            if (q == 0 && p > 0 && pend) begin cur = pd; cdp = pdp; pend = 1'b0; end
            @(negedge clk);
        end
        bus.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_midframe();
        test_lz();
        test_en_drop();
        test_load_on_frame_done();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
